// File: rtl/des_pkg.sv
// DES key-schedule constants: PC-1/PC-2 selection tables, per-round shifts and
// helpers shared by the sequential schedule and any unrolled variant.
package des_pkg;

    localparam int NUM_ROUNDS = 16;

    // Table entries use DES bit numbering: 1 is the MSB of the source word.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef logic [0:0] ks_state_t;
    localparam ks_state_t ST_IDLE = 1'b0;
    localparam ks_state_t ST_GEN  = 1'b1;

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55 - i] = key[64 - PC1[i]];
        end
        return cd;
    endfunction

    function automatic logic odd_parity_ok(input logic [63:0] key);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (^key[8*b +: 8] == 1'b0) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        return (n == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        return (n == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_key_pc2.sv
// PC-2 compression: selects 48 of the 56 C/D bits to form one round key.
module des_key_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] rk
);

    always_comb begin
        rk = '0;
        for (int i = 0; i < 48; i++) begin
            rk[47 - i] = cd[56 - PC2[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: one shared C/D register pair walks the
// schedule forwards (encrypt) or backwards (decrypt), one key per handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | key_ready_o high, waiting for a key; flush_i blocks acceptance
// ST_GEN  | presenting round key rk_round_o, advancing on rk handshake
module des_key_schedule #(
    parameter bit PARITY_CHECK = 1'b0,
    parameter int NUM_ROUNDS   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    output logic        rk_valid_o,
    input  logic        rk_ready_i,
    output logic [47:0] rk_o,
    output logic [3:0]  rk_round_o,
    output logic        rk_last_o,
    output logic        key_err_o,
    input  logic        flush_i
);

    import des_pkg::*;

    if (NUM_ROUNDS != des_pkg::NUM_ROUNDS) begin : g_rounds_check
        $error("des_key_schedule: NUM_ROUNDS is fixed at 16 by DES");
    end

    localparam logic [3:0] LAST_ROUND = 4'(des_pkg::NUM_ROUNDS - 1);

    ks_state_t   state_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  round_q;
    logic        decrypt_q;
    logic        key_err_q;

    logic [55:0] cd_load;
    logic        parity_ok;
    logic [3:0]  idx_enc, idx_dec;
    logic [27:0] c_next, d_next;
    logic [47:0] rk_pc2;

    assign cd_load   = pc1(key_i);
    assign parity_ok = odd_parity_ok(key_i);

    // Encrypt moves to K(round+2), decrypt to K(15-round); both shifts read 0-based.
    assign idx_enc = round_q + 4'd1;
    assign idx_dec = 4'd15 - round_q;
    assign c_next  = decrypt_q ? rotr28(c_q, SHIFT[idx_dec]) : rotl28(c_q, SHIFT[idx_enc]);
    assign d_next  = decrypt_q ? rotr28(d_q, SHIFT[idx_dec]) : rotl28(d_q, SHIFT[idx_enc]);

    // Drivers: flush_i has priority even in IDLE, so a key offered together
    // with flush_i is dropped although key_ready_o reads high that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            d_q       <= '0;
            round_q   <= '0;
            decrypt_q <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            key_err_q <= 1'b0;
            if (flush_i) begin
                state_q <= ST_IDLE;
                c_q     <= '0;
                d_q     <= '0;
                round_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (key_valid_i) begin
                            if (PARITY_CHECK && !parity_ok) begin
                                key_err_q <= 1'b1;
                            end else begin
                                // Decrypt starts from C0/D0: the full rotation equals identity, giving K16.
                                decrypt_q <= decrypt_i;
                                c_q       <= decrypt_i ? cd_load[55:28] : rotl28(cd_load[55:28], 1);
                                d_q       <= decrypt_i ? cd_load[27:0]  : rotl28(cd_load[27:0], 1);
                                round_q   <= '0;
                                state_q   <= ST_GEN;
                            end
                        end
                    end
                    ST_GEN: begin
                        if (rk_ready_i) begin
                            if (round_q == LAST_ROUND) begin
                                state_q <= ST_IDLE;
                                c_q     <= '0;
                                d_q     <= '0;
                                round_q <= '0;
                            end else begin
                                round_q <= round_q + 4'd1;
                                c_q     <= c_next;
                                d_q     <= d_next;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    des_key_pc2 u_pc2 (
        .cd ({c_q, d_q}),
        .rk (rk_pc2)
    );

    assign key_ready_o = (state_q == ST_IDLE);
    assign rk_valid_o  = (state_q == ST_GEN);
    assign rk_o        = rk_valid_o ? rk_pc2 : '0;
    assign rk_round_o  = round_q;
    assign rk_last_o   = rk_valid_o && (round_q == LAST_ROUND);
    assign key_err_o   = key_err_q;

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES round-key generator that sits directly upstream of the round datapath and feeds each round's 48-bit key input. It accepts one 64-bit key over a valid/ready handshake and applies PC-1. It then emits the 16 round keys in order, one per output handshake: K1..K16 for encryption, K16..K1 for decryption. It replaces 16 parallel key-derivation copies with one shared C/D register pair and one PC-2 network.

Parameters:
PARITY_CHECK, 0, 1 = reject keys whose bytes do not all have odd parity (key_err_o pulse, no schedule generated); 0 = ignore parity bits
NUM_ROUNDS, 16, round count; fixed by DES and must not be overridden (elaboration error if != 16)

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
key_valid_i  input  1  key_i/decrypt_i valid
key_ready_o  output  1  block can accept a key (high only in IDLE)
key_i  input  64  DES key, bit 1 = MSB per DES numbering
decrypt_i  input  1  0 = encrypt order, 1 = decrypt order; sampled with the key
rk_valid_o  output  1  rk_o is a valid round key
rk_ready_i  input  1  downstream round consumes rk_o
rk_o  output  48  current round key (PC-2 of C/D register)
rk_round_o  output  4  index of the key being presented, 0..15 = output order position 1..16
rk_last_o  output  1  high with the 16th key of the schedule
key_err_o  output  1  one-cycle pulse: key rejected for parity (PARITY_CHECK=1 only)
flush_i  input  1  synchronous abort of the schedule in progress

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE. C, D and round counter cleared. Outputs: key_ready_o=1, rk_valid_o=0, rk_o=0, rk_round_o=0, rk_last_o=0, key_err_o=0.
- States: IDLE, GEN.
- IDLE: key_ready_o=1.
  - On key_valid_i && key_ready_o, latch decrypt_i and load C/D.
  - Encrypt: C/D = PC-1(key_i) rotated left by 1.
  - Decrypt: C/D = PC-1(key_i) unrotated. The full 28-position rotation is the identity, so K16 = PC-2(PC-1 output).
  - Then set round=0 and go to GEN.
  - If PARITY_CHECK=1 and parity is bad: stay in IDLE, pulse key_err_o the next cycle, load nothing.
- GEN: rk_valid_o=1, rk_o=PC-2(C,D), rk_round_o=round, rk_last_o=(round==15).
  - On rk_valid_o && rk_ready_i with round<15: round+1, and C and D each rotate by the shift for the next key.
  - Encrypt: left by SHIFT[round+2].
  - Decrypt: right by SHIFT[16-round].
  - SHIFT (1-based) = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - On handshake with round==15: go to IDLE.
- Stalls: while rk_valid_o && !rk_ready_i, rk_o, rk_round_o and rk_last_o hold stable. No rotation occurs.
- Latency: first key valid one cycle after key acceptance. With rk_ready_i tied high, one key per cycle; 16 cycles in GEN; next key accepted in the first IDLE cycle. A key costs 17 cycles minimum per schedule.
- key_i and decrypt_i are ignored while key_ready_o=0. No queueing.
- flush_i: next state IDLE, rk_valid_o low next cycle. It overrides a simultaneous rk handshake. In IDLE it blocks acceptance that cycle (key_ready_o is still 1, but flush wins; document this for the driver).
- Async reset mid-GEN: immediate return to reset values; the partial schedule is discarded.
- rk_o is combinational from registers only, never from inputs.

Decomposition:
- Shared package des_pkg holds:
  - PC1 table (56 entries)
  - PC2 table (48 entries)
  - SHIFT table (16 entries)
  - NUM_ROUNDS constant
  - state enum for this block
- One natural sub-module: des_key_pc2, purely combinational 56 -> 48 PC-2 selection, reusable by any unrolled variant.
- PC-1 is applied inline at load.

Test Plan:
- Encrypt key 0x133457799BBCDFF1 with rk_ready_i=1 -> keys on 16 consecutive cycles; K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, K16=0xCB3D8B0E17F5; rk_last_o only with K16; key_ready_o returns the next cycle.
- Same key with decrypt_i=1 -> first rk_o=0xCB3D8B0E17F5, second=K15 of the encrypt run, last=0x1B02EFFC7072; all 16 equal the encrypt sequence reversed.
- Random rk_ready_i backpressure (about 50% duty) -> rk_o and rk_round_o stable across stalled cycles; the sequence is identical to the unstalled run; exactly 16 handshakes.
- Assert key_valid_i during GEN with a different key -> ignored (key_ready_o=0); schedule continues on the original key.
- PARITY_CHECK=1, key 0x133457799BBCDFF0 (byte 8 even parity) -> key_err_o one-cycle pulse, rk_valid_o stays 0; then a valid key proceeds normally.
- flush_i at round 5, and async rst_n low at round 9 in a separate run -> rk_valid_o low (next cycle / immediately), all outputs at reset values, key_ready_o=1; the next key yields a correct full schedule.
